// File: rtl/uart_rx_ctrl_if.sv
// Bundle of configuration, receiver-side and consumer-side signals of uart_rx_ctrl.
// The controller connects through the slave modport, and whatever drives it connects through the master modport.
interface uart_rx_ctrl_if #(
    parameter int DivWidth = 16,
    parameter int Depth    = 4
);
    localparam int LvlW = $clog2(Depth) + 1;

    logic                cfgWr;
    logic [DivWidth-1:0] cfgDiv;
    logic                enable;
    logic                rxEn;
    logic                rxDone;
    logic                rxErr;
    logic [7:0]          rxData;
    logic [7:0]          outData;
    logic                outValid;
    logic                outReady;
    logic [LvlW-1:0]     level;
    logic                overrun;
    logic [7:0]          errCount;
    logic                clrStatus;

    modport master (
        output cfgWr, cfgDiv, enable, rxDone, rxErr, rxData, outReady, clrStatus,
        input  rxEn, outData, outValid, level, overrun, errCount
    );

    modport slave (
        input  cfgWr, cfgDiv, enable, rxDone, rxErr, rxData, outReady, clrStatus,
        output rxEn, outData, outValid, level, overrun, errCount
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator for an oversampling receiver,
// strobe qualification, receive FIFO and sticky status.
module uart_rx_ctrl #(
    parameter int Oversample = 16,
    parameter int DivWidth   = 16,
    parameter int Depth      = 4,
    parameter int DivReset   = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_ctrl_if.slave   bus
);
    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;

    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    localparam logic [DivWidth-1:0] DIV_ZERO = {DivWidth{1'b0}};
    localparam logic [DivWidth-1:0] DIV_ONE  = DivWidth'(1'b1);
    localparam logic [DivWidth-1:0] DIV_RST  = DivWidth'(DivReset);
    localparam logic [LvlW-1:0]     LVL_ZERO = {LvlW{1'b0}};
    localparam logic [LvlW-1:0]     LVL_ONE  = LvlW'(1'b1);
    localparam logic [LvlW-1:0]     LVL_FULL = LvlW'(Depth);
    localparam logic [PtrW-1:0]     PTR_ONE  = PtrW'(1'b1);
    localparam logic [7:0]          ERR_MAX  = 8'hFF;

    generate
        if (Oversample < 2 || Depth < 2 || (Depth & (Depth - 1)) != 0 || DivReset < 1) begin : g_bad_param
            $error("uart_rx_ctrl: illegal parameter set");
        end
    endgenerate

    // A zero divisor would stall the tick counter, so it is stored as 1.
    function automatic logic [DivWidth-1:0] f_clamp_div(input logic [DivWidth-1:0] div);
        return (div == DIV_ZERO) ? DIV_ONE : div;
    endfunction

    logic [0:0]          r_state;
    logic [DivWidth-1:0] r_div;
    logic [DivWidth-1:0] r_cnt;
    logic [7:0]          r_mem [Depth];
    logic [PtrW-1:0]     r_wptr;
    logic [PtrW-1:0]     r_rptr;
    logic [LvlW-1:0]     r_level;
    logic                r_overrun;
    logic [7:0]          r_errcnt;

    logic [DivWidth-1:0] w_new_div;
    logic                w_tick;
    logic                w_push;
    logic                w_err;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;
    logic                w_drop;

    // Tick decode, strobe qualification and FIFO handshake decisions.
    always_comb begin
        w_new_div = f_clamp_div(bus.cfgDiv);
        w_tick    = (r_state == ST_RUN) && (r_cnt == DIV_ZERO) && !bus.cfgWr;
        w_push    = w_tick && bus.rxDone;
        w_err     = w_tick && bus.rxErr;
        w_pop     = (r_level != LVL_ZERO) && bus.outReady;
        w_full    = (r_level == LVL_FULL);
        w_accept  = w_push && (!w_full || w_pop);
        w_drop    = w_push && w_full && !w_pop;
    end

    // Run state, divisor register and tick counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_div   <= DIV_RST;
            r_cnt   <= DIV_RST - DIV_ONE;
        end else begin
            r_state <= bus.enable ? ST_RUN : ST_OFF;
            if (bus.cfgWr) begin
                r_div <= w_new_div;
                r_cnt <= w_new_div - DIV_ONE;
            end else if (r_state == ST_OFF) begin
                r_cnt <= r_div - DIV_ONE;
            end else if (r_cnt == DIV_ZERO) begin
                r_cnt <= r_div - DIV_ONE;
            end else begin
                r_cnt <= r_cnt - DIV_ONE;
            end
        end
    end

    // Receive FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr  <= {PtrW{1'b0}};
            r_rptr  <= {PtrW{1'b0}};
            r_level <= LVL_ZERO;
        end else begin
            if (w_accept) begin
                r_mem[r_wptr] <= bus.rxData;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overrun flag and saturating framing-error count; clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_errcnt  <= 8'h00;
        end else if (bus.clrStatus) begin
            r_overrun <= 1'b0;
            r_errcnt  <= 8'h00;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_err && (r_errcnt != ERR_MAX)) begin
                r_errcnt <= r_errcnt + 8'h01;
            end
        end
    end

    assign bus.rxEn     = w_tick;
    assign bus.outData  = r_mem[r_rptr];
    assign bus.outValid = (r_level != LVL_ZERO);
    assign bus.level    = r_level;
    assign bus.overrun  = r_overrun;
    assign bus.errCount = r_errcnt;
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The module SHALL have parameters, one per line:
- Oversample, 16, samples per bit expected by the attached receiver (informational; must be ≥2).
- DivWidth, 16, width of the baud divisor.
- Depth, 4, receive FIFO entries (power of two, ≥2).
- DivReset, 1, divisor value after reset.

REQ-002 The module SHALL have ports, one per line:
- clk, in, 1, sole clock; all state on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- cfgWr, in, 1, load cfgDiv into the divisor register.
- cfgDiv, in, DivWidth, new divisor (clk cycles per rxEn tick).
- enable, in, 1, run request.
- rxEn, out, 1, single-cycle sample tick to the receiver's en input.
- rxDone, in, 1, receiver byte-complete strobe.
- rxErr, in, 1, receiver framing-error strobe.
- rxData, in, 8, receiver data bus.
- outData, out, 8, FIFO head byte.
- outValid, out, 1, FIFO non-empty.
- outReady, in, 1, consumer accepts head.
- level, out, $clog2(Depth)+1, FIFO occupancy.
- overrun, out, 1, sticky: a byte was dropped.
- errCount, out, 8, saturating framing-error count.
- clrStatus, in, 1, clears overrun and errCount.

REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.

Function
REQ-004 The controller SHALL have states OFF and RUN.
- OFF→RUN on enable=1.
- RUN→OFF on enable=0.
- Transitions take effect on the next clock edge.

REQ-005 The divisor register SHALL load cfgDiv on any cycle with cfgWr=1, in either state.
- A loaded value of 0 SHALL be stored as 1.

REQ-006 Tick counter behaviour:
- In RUN, the tick counter decrements each cycle.
- rxEn=1 exactly in cycles where the counter equals 0 and the state is RUN.
- On reaching 0, the counter reloads divisor−1.
- Resulting tick period equals the divisor (divisor 1 gives rxEn=1 every RUN cycle).

REQ-007 The tick counter SHALL be loaded with divisor−1 in these cases:
- in OFF;
- on the OFF→RUN transition;
- on a cfgWr cycle, using the new value.

No rxEn SHALL be issued in a cfgWr cycle.

REQ-008 rxEn SHALL be 0 in OFF.

REQ-009 Strobe qualification:
- rxDone and rxErr SHALL be sampled only in cycles where rxEn=1.
- Strobes in other cycles SHALL be ignored.

REQ-010 Push: qualified rxDone SHALL push rxData into the FIFO tail in the same edge.

REQ-011 Pop: outValid&&outReady SHALL pop the head.
- outData SHALL always present the head entry (don't-care when empty).

REQ-012 FIFO boundary cases:
- Push and pop in the same cycle SHALL both take effect, including when full; level is unchanged.
- Push when full with no pop SHALL drop the byte, set overrun, and leave contents unchanged.
- Pop when empty is impossible, since outValid=0.

REQ-013 Read and write pointers SHALL wrap modulo Depth; level SHALL range 0..Depth.

REQ-014 Framing errors: a qualified rxErr SHALL increment errCount, saturating at 255, and SHALL NOT push.

REQ-015 rxDone and rxErr both qualified in the same cycle SHALL push and increment.

REQ-016 clrStatus=1 SHALL zero overrun and errCount on the next edge.
- clrStatus SHALL take priority over a same-cycle overrun or increment event.

REQ-017 RUN→OFF SHALL NOT flush the FIFO; stored bytes remain poppable in OFF.

Reset
REQ-018 While reset=1, the following SHALL hold asynchronously:
- state=OFF;
- divisor=DivReset;
- tick counter=DivReset−1;
- FIFO empty (pointers 0);
- rxEn=0, outValid=0, level=0, overrun=0, errCount=0, outData=0.

REQ-019 Reset asserted mid-operation SHALL discard FIFO contents and pending ticks.
- After release, no rxEn SHALL occur until enable is seen high in RUN.

Verification
REQ-020 Tick rate:
- Stimulus: cfgWr cfgDiv=5, then enable=1 for 50 cycles.
- Response: rxEn pulses every 5th cycle, first pulse 5 cycles after entering RUN; cfgDiv=0 gives rxEn every cycle.

REQ-021 FIFO order:
- Stimulus: Depth=4, outReady=0; push 0xA5, 0x3C, 0xFF, 0x00 via qualified rxDone.
- Response: level=4; then outReady=1 pops A5, 3C, FF, 00 in order and outValid falls after the 4th pop.

REQ-022 Overrun:
- Stimulus: FIFO full, 5th qualified rxDone with data 0x77, outReady=0.
- Response: overrun=1, level=4, 0x77 never appears.
- Repeat with outReady=1 in the same cycle: push accepted, overrun stays 0.

REQ-023 Qualification:
- Stimulus: rxDone=1 in a cycle with rxEn=0.
- Response: no push.
- Stimulus: 300 qualified rxErr pulses.
- Response: errCount=255; clrStatus concurrent with an rxErr gives errCount=0.

REQ-024 Disable and reset:
- Stimulus: 2 bytes queued, enable=0.
- Response: rxEn stops next cycle, both bytes still poppable.
- Stimulus: reset pulse mid-stream.
- Response: all outputs at REQ-018 values immediately, without waiting for a clock edge.
